xosera_bus_ctrl: RTL and testbench
==================================

Name: xosera_bus_ctrl

Overview:
- Sequences 68k bus cycles into Xosera's register interface.
- Synchronizes the asynchronous bus_* pins into the clk domain and qualifies each chip-select cycle.
- Issues one-cycle register write or read strobes, returns read data and generates DTACK.
- Sits between the board top-level pin split (tri-state in/out) and the register file inside xosera_main.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of input synchronizers (legal 2..3).
- RD_TIMEOUT, 15, clk cycles to wait for reg_rd_valid_i before forcing completion (legal 1..255).
- TIMEOUT_DATA, 8'hFF, byte returned on read timeout.

Ports:
- clk  in  1  pixel clock; sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- bus_cs_n_i  in  1  raw 68k chip select, active low (xv::CS_ENABLED).
- bus_rd_nwr_i  in  1  raw read/not-write (xv::RnW_READ = read).
- bus_bytesel_i  in  1  raw byte select.
- bus_reg_num_i  in  4  raw register number.
- bus_data_i  in  8  raw write data from pin split.
- bus_data_o  out  8  read data to pin split.
- bus_dtack_o  out  1  DTACK pin level, active low (0 = acknowledge).
- reg_wr_o  out  1  one-cycle register write strobe.
- reg_rd_o  out  1  one-cycle register read request.
- reg_num_o  out  4  latched register number.
- reg_bytesel_o  out  1  latched byte select.
- reg_data_o  out  8  latched write data.
- reg_rd_data_i  in  8  register read data.
- reg_rd_valid_i  in  1  read data valid (may be high the same cycle as reg_rd_o).
- timeout_o  out  1  one-cycle pulse when a read times out.

Behaviour:
- Reset (async, immediate): state IDLE; bus_dtack_o=1; bus_data_o=0; reg_wr_o=reg_rd_o=timeout_o=0; reg_num_o=0; reg_bytesel_o=0; reg_data_o=0; synchronizer chains preset to 1 for cs_n and 0 for the others.
- All bus_* inputs pass through SYNC_STAGES flops; cs_s, rnw_s, bsel_s, num_s and data_s denote the synchronized values.
- States: IDLE, SETTLE, STROBE, RD_WAIT, ACK, RELEASE.
- IDLE: on cs_s==0 go to SETTLE (cycle N).
- SETTLE (N+1):
  - If cs_s==1, it is a glitch: return to IDLE with no strobe and no DTACK.
  - Otherwise latch num_s into reg_num_o, bsel_s into reg_bytesel_o, data_s into reg_data_o and rnw_s internally; go to STROBE.
- STROBE (N+2):
  - Write: reg_wr_o=1 for exactly this cycle; go to ACK.
  - Read: reg_rd_o=1 for exactly this cycle; clear the timeout counter; if reg_rd_valid_i is high, capture reg_rd_data_i and go to ACK, else go to RD_WAIT.
- RD_WAIT:
  - Counter increments each cycle.
  - On reg_rd_valid_i: capture reg_rd_data_i into bus_data_o and go to ACK.
  - If the counter reaches RD_TIMEOUT first: bus_data_o=TIMEOUT_DATA, timeout_o=1 for one cycle, go to ACK.
  - If valid arrives on the same cycle as the timeout, valid wins and no timeout is flagged.
- ACK:
  - bus_dtack_o driven 0 from entry and held through RELEASE.
  - bus_data_o stable for the whole ACK/RELEASE period.
  - Write latency: DTACK low at N+3. Read with immediate valid: DTACK low at N+3.
  - Go to RELEASE.
- RELEASE: wait for cs_s==1, then bus_dtack_o=1 the next cycle and go to IDLE. A new cycle cannot start until cs_s has been observed high.
- CS deasserted during RD_WAIT (master aborted):
  - Go to IDLE at once, with no DTACK and no timeout_o.
  - A reg_rd_valid_i arriving later is ignored.
- Strobes never overlap; at most one strobe per cs cycle.
- rnw_s changing after SETTLE is ignored.
- Reset asserted mid-cycle: async return to IDLE with DTACK released (1). After reset release, if cs is still low, a fresh cycle is taken only after sync latency (treated as a new cycle).
- Counter width is $clog2(RD_TIMEOUT+1); no wrap, because it saturates at RD_TIMEOUT.

Decomposition:
- Package xv:
  - typedef enum logic [2:0] bus_state_t {IDLE, SETTLE, STROBE, RD_WAIT, ACK, RELEASE}.
  - Existing CS_ENABLED and RnW_READ constants.
  - New DTACK_ASSERTED=1'b0 and DTACK_RELEASED=1'b1.
- Sub-module xosera_sync:
  - Parameterized width, depth and reset value.
  - Asynchronous active-high reset.
  - Instantiated once for the control bits and once for the num/data buses.

Test Plan:
- Write cycle: cs_n low, rnw=0, reg_num=4'h5, bytesel=1, data=8'hA3, held until DTACK → reg_wr_o pulses one cycle at N+2 with reg_num_o=5, reg_bytesel_o=1, reg_data_o=A3; bus_dtack_o=0 at N+3; DTACK returns to 1 one cycle after cs_s rises.
- Read with 3-cycle latency: reg_num=4'hC, reg_rd_valid_i high 3 cycles after reg_rd_o with data 8'h5E → exactly one reg_rd_o pulse; bus_data_o=5E when bus_dtack_o falls; no timeout_o.
- Read timeout: RD_TIMEOUT=4, valid never asserted → timeout_o pulses once; bus_data_o=FF; DTACK asserted; normal release.
- Glitch: cs_n low for 1 raw clk (SYNC_STAGES=2) → no reg_wr_o, reg_rd_o or DTACK; state back to IDLE.
- Abort and reset: cs_n released during RD_WAIT → no DTACK and no timeout_o. Separately, reset_i pulsed while in ACK → bus_dtack_o=1 asynchronously (before next clk edge) and all strobes 0.
- Back-to-back: two writes separated by 2 clk of cs_n high → two reg_wr_o pulses; the second cycle is not merged into the first.

Source files
------------

// File: rtl/xosera_bus_ctrl_pkg.sv
// Shared bus-interface constants and the bus cycle sequencer state type.
package xv;

  // Level of the 68k chip select when this device is selected
  localparam logic CS_ENABLED     = 1'b0;
  // Level of read/not-write for a read cycle
  localparam logic RnW_READ       = 1'b1;
  // DTACK pin levels (open-collector style, low acknowledges)
  localparam logic DTACK_ASSERTED = 1'b0;
  localparam logic DTACK_RELEASED = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STROBE,
    RD_WAIT,
    ACK,
    RELEASE
  } bus_state_t;

endpackage

// File: rtl/xosera_bus_ctrl_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs.
// All bits of one bundle share the same depth so they stay mutually aligned.
module xosera_sync #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_chain;

  // Shift the raw input through DEPTH flops; reset presets every stage
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= {DEPTH{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/xosera_bus_ctrl.sv
// 68k bus cycle sequencer: synchronizes the bus pins, qualifies each
// chip-select cycle, issues one register strobe per cycle, returns read data
// (or a timeout byte) and drives DTACK until the master drops chip select.
module xosera_bus_ctrl
  import xv::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter int         RD_TIMEOUT   = 15,
  parameter logic [7:0] TIMEOUT_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       bus_cs_n_i,
  input  logic       bus_rd_nwr_i,
  input  logic       bus_bytesel_i,
  input  logic [3:0] bus_reg_num_i,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_dtack_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [3:0] reg_num_o,
  output logic       reg_bytesel_o,
  output logic [7:0] reg_data_o,
  input  logic [7:0] reg_rd_data_i,
  input  logic       reg_rd_valid_i,
  output logic       timeout_o
);

  localparam int             CW      = $clog2(RD_TIMEOUT + 1);
  // Last counter value before the read is declared timed out
  localparam logic [CW-1:0]  TO_LAST = CW'(RD_TIMEOUT - 1);

  logic [2:0]  w_ctrl_s;
  logic [11:0] w_bus_s;
  logic        w_cs_s;
  logic        w_rnw_s;
  logic        w_bsel_s;
  logic [3:0]  w_num_s;
  logic [7:0]  w_data_s;

  // Control pins: chip select idles high (deselected), others idle low
  xosera_sync #(
    .WIDTH    (3),
    .DEPTH    (SYNC_STAGES),
    .RESET_VAL(3'b100)
  ) u_sync_ctrl (
    .clk  (clk),
    .i_rst(reset_i),
    .i_d  ({bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i}),
    .o_q  (w_ctrl_s)
  );

  // Register number and write data, same depth as control so they line up
  xosera_sync #(
    .WIDTH    (12),
    .DEPTH    (SYNC_STAGES),
    .RESET_VAL(12'h000)
  ) u_sync_bus (
    .clk  (clk),
    .i_rst(reset_i),
    .i_d  ({bus_reg_num_i, bus_data_i}),
    .o_q  (w_bus_s)
  );

  assign {w_cs_s, w_rnw_s, w_bsel_s} = w_ctrl_s;
  assign {w_num_s, w_data_s}         = w_bus_s;

  bus_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rnw;
  logic          r_dtack;
  logic [7:0]    r_rd_data;
  logic          r_wr;
  logic          r_rd;
  logic          r_timeout;
  logic [3:0]    r_num;
  logic          r_bsel;
  logic [7:0]    r_wdata;

  // Bus cycle sequencer with registered strobes, DTACK and read data
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rnw     <= 1'b0;
      r_dtack   <= DTACK_RELEASED;
      r_rd_data <= 8'h00;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_timeout <= 1'b0;
      r_num     <= 4'h0;
      r_bsel    <= 1'b0;
      r_wdata   <= 8'h00;
    end else begin
      // Strobes and timeout are single-cycle pulses by default
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_s == CS_ENABLED) begin
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          // A select that vanished after one cycle is a glitch, not a cycle
          if (w_cs_s != CS_ENABLED) begin
            r_state <= IDLE;
          end else begin
            r_num   <= w_num_s;
            r_bsel  <= w_bsel_s;
            r_wdata <= w_data_s;
            r_rnw   <= w_rnw_s;
            if (w_rnw_s == RnW_READ) begin
              r_rd <= 1'b1;
            end else begin
              r_wr <= 1'b1;
            end
            r_state <= STROBE;
          end
        end
        STROBE: begin
          r_cnt <= '0;
          if (r_rnw != RnW_READ) begin
            r_dtack <= DTACK_ASSERTED;
            r_state <= ACK;
          end else if (reg_rd_valid_i) begin
            r_rd_data <= reg_rd_data_i;
            r_dtack   <= DTACK_ASSERTED;
            r_state   <= ACK;
          end else begin
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Master abort wins over everything; valid wins over timeout
          if (w_cs_s != CS_ENABLED) begin
            r_state <= IDLE;
          end else if (reg_rd_valid_i) begin
            r_rd_data <= reg_rd_data_i;
            r_dtack   <= DTACK_ASSERTED;
            r_state   <= ACK;
          end else if (r_cnt == TO_LAST) begin
            r_rd_data <= TIMEOUT_DATA;
            r_timeout <= 1'b1;
            r_dtack   <= DTACK_ASSERTED;
            r_state   <= ACK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ACK: begin
          r_state <= RELEASE;
        end
        RELEASE: begin
          // Hold DTACK until the master is seen to deselect
          if (w_cs_s != CS_ENABLED) begin
            r_dtack <= DTACK_RELEASED;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus_data_o    = r_rd_data;
  assign bus_dtack_o   = r_dtack;
  assign reg_wr_o      = r_wr;
  assign reg_rd_o      = r_rd;
  assign reg_num_o     = r_num;
  assign reg_bytesel_o = r_bsel;
  assign reg_data_o    = r_wdata;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Bench for xosera_bus_ctrl: directed bus cycles plus randomized cycles
// checked against a cycle-count model of the bus protocol.
module tb_xosera_bus_ctrl;

  localparam int         SYNC  = 2;
  localparam int         TMO   = 4;
  localparam logic [7:0] TDATA = 8'hFF;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       bus_cs_n_i;
  logic       bus_rd_nwr_i;
  logic       bus_bytesel_i;
  logic [3:0] bus_reg_num_i;
  logic [7:0] bus_data_i;
  logic [7:0] bus_data_o;
  logic       bus_dtack_o;
  logic       reg_wr_o;
  logic       reg_rd_o;
  logic [3:0] reg_num_o;
  logic       reg_bytesel_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_rd_data_i;
  logic       reg_rd_valid_i;
  logic       timeout_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  xosera_bus_ctrl #(
    .SYNC_STAGES (SYNC),
    .RD_TIMEOUT  (TMO),
    .TIMEOUT_DATA(TDATA)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .bus_cs_n_i    (bus_cs_n_i),
    .bus_rd_nwr_i  (bus_rd_nwr_i),
    .bus_bytesel_i (bus_bytesel_i),
    .bus_reg_num_i (bus_reg_num_i),
    .bus_data_i    (bus_data_i),
    .bus_data_o    (bus_data_o),
    .bus_dtack_o   (bus_dtack_o),
    .reg_wr_o      (reg_wr_o),
    .reg_rd_o      (reg_rd_o),
    .reg_num_o     (reg_num_o),
    .reg_bytesel_o (reg_bytesel_o),
    .reg_data_o    (reg_data_o),
    .reg_rd_data_i (reg_rd_data_i),
    .reg_rd_valid_i(reg_rd_valid_i),
    .timeout_o     (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Release chip select and expect DTACK high after sync latency + 1 cycle
  task automatic release_wait(input string tag);
    int rel_k = 0;
    bus_cs_n_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_dtack_o === 1'b1) begin
        rel_k = k;
        break;
      end
    end
    chk(tag, rel_k, SYNC + 1);
  endtask

  // One complete bus cycle; expectations come from protocol timing rules:
  // strobe SYNC+2 cycles after cs falls, DTACK 1 cycle after a write strobe,
  // 1+min(lat,TMO) cycles after a read strobe, timeout only when lat > TMO.
  task automatic do_cycle(input string name, input bit rnw, input logic [3:0] num,
                          input bit bsel, input logic [7:0] wdata,
                          input int lat, input logic [7:0] rdata);
    int wr_n = 0, rd_n = 0, to_n = 0, stb_k = 0, ack_k = 0, rel_k = 0, drift = 0;
    logic [3:0] s_num = 4'hx;
    logic       s_bsel = 1'bx;
    logic [7:0] s_wdata = 8'hxx;
    logic [7:0] ack_data = 8'hxx;
    bit         exp_to;
    int         exp_lat;
    logic [7:0] exp_data;
    exp_to   = rnw && (lat > TMO);
    exp_lat  = rnw ? 1 + ((lat < TMO) ? lat : TMO) : 1;
    exp_data = exp_to ? TDATA : rdata;

    bus_rd_nwr_i  = rnw;
    bus_reg_num_i = num;
    bus_bytesel_i = bsel;
    bus_data_i    = wdata;
    bus_cs_n_i    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (reg_wr_o === 1'b1) begin
        wr_n++; stb_k = k;
        s_num = reg_num_o; s_bsel = reg_bytesel_o; s_wdata = reg_data_o;
        bus_rd_nwr_i = ~rnw;  // late direction change must be ignored
      end
      if (reg_rd_o === 1'b1) begin
        rd_n++; stb_k = k;
        s_num = reg_num_o; s_bsel = reg_bytesel_o; s_wdata = reg_data_o;
        bus_rd_nwr_i = ~rnw;
      end
      if (timeout_o === 1'b1) to_n++;
      reg_rd_valid_i = (rd_n > 0) && (k == stb_k + lat);
      reg_rd_data_i  = reg_rd_valid_i ? rdata : ~rdata;
      if (bus_dtack_o === 1'b0) begin
        ack_k = k;
        ack_data = bus_data_o;
        break;
      end
    end
    reg_rd_valid_i = 1'b0;

    bus_cs_n_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout_o === 1'b1) to_n++;
      if (reg_wr_o === 1'b1) wr_n++;
      if (reg_rd_o === 1'b1) rd_n++;
      if (bus_dtack_o === 1'b1) begin
        rel_k = k;
        break;
      end
      if (bus_data_o !== ack_data) drift++;
    end

    chk({name, ".wr_count"}, wr_n, rnw ? 0 : 1);
    chk({name, ".rd_count"}, rd_n, rnw ? 1 : 0);
    chk({name, ".strobe_cycle"}, stb_k, SYNC + 2);
    chk({name, ".ack_latency"}, ack_k - stb_k, exp_lat);
    chk({name, ".reg_num"}, s_num, num);
    chk({name, ".reg_bytesel"}, s_bsel, bsel);
    chk({name, ".reg_data"}, s_wdata, wdata);
    if (rnw) chk({name, ".rd_data"}, ack_data, exp_data);
    chk({name, ".timeout_count"}, to_n, exp_to);
    chk({name, ".release_cycle"}, rel_k, SYNC + 1);
    chk({name, ".data_stable"}, drift, 0);
    n_txn++;
    $display("txn %0d %s: %s num=%h bsel=%0d wdata=%h lat=%0d rdata=%h -> ack+%0d data=%h to=%0d",
             n_txn, name, rnw ? "RD" : "WR", num, bsel, wdata, lat, rdata,
             ack_k - stb_k, ack_data, to_n);
  endtask

  initial begin
    int cnt_wr, cnt_rd, cnt_ack, cnt_to, wr_k, saw_high, ack_seen;
    logic [7:0] d_first, d_second;

    reset_i        = 1'b1;
    bus_cs_n_i     = 1'b1;
    bus_rd_nwr_i   = 1'b0;
    bus_bytesel_i  = 1'b0;
    bus_reg_num_i  = 4'h0;
    bus_data_i     = 8'h00;
    reg_rd_data_i  = 8'h00;
    reg_rd_valid_i = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset.dtack", bus_dtack_o, 1'b1);
    chk("reset.bus_data", bus_data_o, 8'h00);
    chk("reset.strobes", {reg_wr_o, reg_rd_o, timeout_o}, 3'b000);
    chk("reset.reg_num", reg_num_o, 4'h0);
    chk("reset.reg_bytesel", reg_bytesel_o, 1'b0);
    chk("reset.reg_data", reg_data_o, 8'h00);
    reset_i = 1'b0;
    @(negedge clk);

    // Directed cycles
    do_cycle("write", 1'b0, 4'h5, 1'b1, 8'hA3, 0, 8'h00);
    do_cycle("read_lat3", 1'b1, 4'hC, 1'b0, 8'h11, 3, 8'h5E);
    do_cycle("read_timeout", 1'b1, 4'h2, 1'b1, 8'h22, 999, 8'h44);
    do_cycle("read_lat_eq_tmo", 1'b1, 4'h7, 1'b0, 8'h33, TMO, 8'h9D);
    do_cycle("read_lat_tmo_p1", 1'b1, 4'h8, 1'b1, 8'h34, TMO + 1, 8'h6B);
    do_cycle("read_immediate", 1'b1, 4'hF, 1'b1, 8'h55, 0, 8'hC7);

    // Glitch: one raw cycle of chip select
    bus_rd_nwr_i = 1'b0;
    bus_cs_n_i = 1'b0;
    @(negedge clk);
    bus_cs_n_i = 1'b1;
    cnt_wr = 0; cnt_rd = 0; cnt_ack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (reg_wr_o === 1'b1) cnt_wr++;
      if (reg_rd_o === 1'b1) cnt_rd++;
      if (bus_dtack_o !== 1'b1) cnt_ack++;
    end
    chk("glitch.wr", cnt_wr, 0);
    chk("glitch.rd", cnt_rd, 0);
    chk("glitch.dtack", cnt_ack, 0);
    $display("txn glitch: wr=%0d rd=%0d dtack_low=%0d", cnt_wr, cnt_rd, cnt_ack);

    // Abort: master drops chip select while the read is waiting
    bus_rd_nwr_i  = 1'b1;
    bus_reg_num_i = 4'h9;
    bus_cs_n_i    = 1'b0;
    cnt_rd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reg_rd_o === 1'b1) begin
        cnt_rd++;
        break;
      end
    end
    chk("abort.rd_seen", cnt_rd, 1);
    @(negedge clk);
    bus_cs_n_i = 1'b1;
    cnt_wr = 0; cnt_ack = 0; cnt_to = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      reg_rd_valid_i = (k == 12);
      reg_rd_data_i  = 8'h77;
      if (reg_wr_o === 1'b1 || reg_rd_o === 1'b1) cnt_wr++;
      if (bus_dtack_o !== 1'b1) cnt_ack++;
      if (timeout_o === 1'b1) cnt_to++;
    end
    reg_rd_valid_i = 1'b0;
    chk("abort.extra_strobes", cnt_wr, 0);
    chk("abort.dtack", cnt_ack, 0);
    chk("abort.timeout", cnt_to, 0);
    $display("txn abort: dtack_low=%0d timeout=%0d", cnt_ack, cnt_to);

    // Reset pulsed while DTACK is asserted
    bus_rd_nwr_i  = 1'b0;
    bus_reg_num_i = 4'h3;
    bus_data_i    = 8'h3C;
    bus_cs_n_i    = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_dtack_o === 1'b0) begin
        ack_seen = 1;
        break;
      end
    end
    chk("rst_ack.ack_seen", ack_seen, 1);
    #1 reset_i = 1'b1;
    #1;
    chk("rst_ack.dtack_async", bus_dtack_o, 1'b1);
    chk("rst_ack.strobes", {reg_wr_o, reg_rd_o, timeout_o}, 3'b000);
    chk("rst_ack.reg_data", reg_data_o, 8'h00);
    @(negedge clk);
    reset_i = 1'b0;
    bus_data_i = 8'hC5;
    cnt_wr = 0; wr_k = 0; d_first = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (reg_wr_o === 1'b1) begin
        cnt_wr++; wr_k = k; d_first = reg_data_o;
      end
      if (bus_dtack_o === 1'b0) break;
    end
    chk("rst_ack.new_wr_count", cnt_wr, 1);
    chk("rst_ack.new_wr_cycle", wr_k, SYNC + 2);
    chk("rst_ack.new_wr_data", d_first, 8'hC5);
    release_wait("rst_ack.release");
    $display("txn reset_in_ack: new_wr=%0d at %0d data=%h", cnt_wr, wr_k, d_first);

    // Back-to-back writes with two raw cycles of chip select high between
    bus_rd_nwr_i  = 1'b0;
    bus_reg_num_i = 4'h1;
    bus_data_i    = 8'h5A;
    bus_cs_n_i    = 1'b0;
    cnt_wr = 0; d_first = 8'h00; d_second = 8'h00; saw_high = 0; ack_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (reg_wr_o === 1'b1) begin cnt_wr++; d_first = reg_data_o; end
      if (bus_dtack_o === 1'b0) begin ack_seen++; break; end
    end
    bus_cs_n_i = 1'b1;
    @(negedge clk);
    if (reg_wr_o === 1'b1) cnt_wr++;
    @(negedge clk);
    if (reg_wr_o === 1'b1) cnt_wr++;
    bus_data_i = 8'hA5;
    bus_cs_n_i = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_dtack_o === 1'b1) saw_high = 1;
      if (reg_wr_o === 1'b1) begin cnt_wr++; d_second = reg_data_o; end
      if (saw_high == 1 && bus_dtack_o === 1'b0) begin ack_seen++; break; end
    end
    chk("b2b.wr_count", cnt_wr, 2);
    chk("b2b.first_data", d_first, 8'h5A);
    chk("b2b.second_data", d_second, 8'hA5);
    chk("b2b.dtack_gap", saw_high, 1);
    chk("b2b.ack_count", ack_seen, 2);
    release_wait("b2b.release");
    $display("txn back_to_back: wr=%0d data=%h,%h acks=%0d", cnt_wr, d_first, d_second, ack_seen);

    // Randomized cycles
    for (int i = 0; i < 24; i++) begin
      do_cycle("random", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
               8'($urandom), int'($urandom_range(0, TMO + 2)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
